// File: rtl/fs_accel_cfg_regbank_pkg.sv
// Shared constants for the accelerator config register bank: register selects,
// status bit positions and default parameter values.
package fs_accel_cfg_regbank_pkg;

  localparam int DEF_NUM_REGS   = 19;
  localparam int DEF_NUM_LANES  = 3;
  localparam int DEF_QBUF_DEPTH = 36;
  localparam int DEF_GRP_W      = 4;

  // Quant pointer width covers the largest allowed buffer depth (64 entries).
  localparam int QPTR_W = 6;

  localparam logic [4:0] SEL_QPTR   = 5'd12;
  localparam logic [4:0] SEL_QMULT  = 5'd13;
  localparam logic [4:0] SEL_QSHIFT = 5'd14;
  localparam logic [4:0] SEL_STATUS = 5'd30;
  localparam logic [4:0] SEL_ERRCLR = 5'd31;

  localparam int ST_ERR  = 0;
  localparam int ST_BUSY = 1;
  localparam int ST_PEND = 2;

  function automatic logic is_quant_sel(input logic [4:0] sel);
    return (sel == SEL_QPTR) || (sel == SEL_QMULT) || (sel == SEL_QSHIFT);
  endfunction

endpackage

// File: rtl/fs_accel_quant_buf.sv
// Quant multiplier/shift storage with a registered per-group lane mux.
// Group g (1-based) presents entries (g-1)*NUM_LANES+k on lane k; group 0 or out of range gives zeros.
module fs_accel_quant_buf
  import fs_accel_cfg_regbank_pkg::*;
#(
  parameter int NUM_LANES  = DEF_NUM_LANES,
  parameter int QBUF_DEPTH = DEF_QBUF_DEPTH,
  parameter int GRP_W      = DEF_GRP_W
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   mult_we,
  input  logic                   shift_we,
  input  logic [QPTR_W-1:0]      addr,
  input  logic [31:0]            wdata,
  input  logic [GRP_W-1:0]       grp_sel,
  output logic [31:0]            rd_mult,
  output logic [7:0]             rd_shift,
  output logic [NUM_LANES*32-1:0] quant_mult,
  output logic [NUM_LANES*8-1:0]  quant_shift
);

  localparam int NGRP = QBUF_DEPTH / NUM_LANES;

  logic [31:0]              mult_q  [QBUF_DEPTH];
  logic [7:0]               shift_q [QBUF_DEPTH];
  logic [NUM_LANES*32-1:0]  qmult_d, qmult_q;
  logic [NUM_LANES*8-1:0]   qshift_d, qshift_q;
  logic [QPTR_W-1:0]        idx;

  assign rd_mult     = mult_q[addr];
  assign rd_shift    = shift_q[addr];
  assign quant_mult  = qmult_q;
  assign quant_shift = qshift_q;

  always_comb begin
    qmult_d  = '0;
    qshift_d = '0;
    idx      = '0;
    if ((grp_sel != '0) && (int'(grp_sel) <= NGRP)) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        idx = QPTR_W'((int'(grp_sel) - 1) * NUM_LANES + k);
        qmult_d[32*k +: 32] = mult_q[idx];
        qshift_d[8*k +: 8]  = shift_q[idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < QBUF_DEPTH; i++) begin
        mult_q[i]  <= '0;
        shift_q[i] <= '0;
      end
      qmult_q  <= '0;
      qshift_q <= '0;
    end else begin
      if (mult_we)  mult_q[addr]  <= wdata;
      if (shift_we) shift_q[addr] <= wdata[7:0];
      qmult_q  <= qmult_d;
      qshift_q <= qshift_d;
    end
  end

endmodule

// File: rtl/fs_accel_cfg_regbank.sv
// Shadow/active config register bank with deferred commit and quant table access.
// Optional readback port enabled by defining FS_ACCEL_CFG_READBACK_EN.
module fs_accel_cfg_regbank
  import fs_accel_cfg_regbank_pkg::*;
#(
  parameter int NUM_REGS   = DEF_NUM_REGS,
  parameter int NUM_LANES  = DEF_NUM_LANES,
  parameter int QBUF_DEPTH = DEF_QBUF_DEPTH,
  parameter int GRP_W      = DEF_GRP_W
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    cfg_wen,
  input  logic [4:0]              cfg_sel,
  input  logic [31:0]             cfg_wdata,
  input  logic                    cfg_ren,
  output logic [31:0]             cfg_rdata,
  output logic                    cfg_rvalid,
  input  logic                    cfg_commit,
  input  logic                    layer_busy,
  output logic                    commit_pending,
  output logic                    commit_done,
  input  logic [GRP_W-1:0]        quant_grp_sel,
  output logic [NUM_REGS*32-1:0]  active_regs,
  output logic [NUM_LANES*32-1:0] quant_mult,
  output logic [NUM_LANES*8-1:0]  quant_shift,
  output logic                    cfg_err
);

  logic [NUM_REGS-1:0][31:0] shadow_q, shadow_d, active_q, active_d;
  logic [QPTR_W-1:0]         qptr_q, qptr_d;
  logic                      err_q, err_d, pend_q, pend_d, done_q, done_d;
  logic                      is_quant, is_shadow, commit_req, mult_we, shift_we;
  logic [31:0]               rd_mult;
  logic [7:0]                rd_shift;
  logic [31:0]               status;

  assign is_quant   = is_quant_sel(cfg_sel);
  assign is_shadow  = ({27'b0, cfg_sel} < 32'(NUM_REGS)) && !is_quant;
  assign commit_req = cfg_commit || pend_q;

  always_comb begin
    status          = '0;
    status[ST_ERR]  = err_q;
    status[ST_BUSY] = layer_busy;
    status[ST_PEND] = pend_q;
  end

  always_comb begin
    shadow_d = shadow_q;
    qptr_d   = qptr_q;
    err_d    = err_q;
    mult_we  = 1'b0;
    shift_we = 1'b0;
    if (cfg_wen) begin
      if (is_shadow) begin
        shadow_d[cfg_sel] = cfg_wdata;
      end else if (cfg_sel == SEL_ERRCLR) begin
        err_d = 1'b0;
      end else if (is_quant) begin
        if (layer_busy) begin
          err_d = 1'b1;
        end else if (cfg_sel == SEL_QPTR) begin
          if (cfg_wdata < 32'(QBUF_DEPTH)) qptr_d = cfg_wdata[QPTR_W-1:0];
          else                             err_d  = 1'b1;
        end else if (cfg_sel == SEL_QMULT) begin
          mult_we = 1'b1;
        end else begin
          shift_we = 1'b1;
          qptr_d   = (qptr_q == QPTR_W'(QBUF_DEPTH - 1)) ? '0 : qptr_q + 1'b1;
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // Commit copies the pre-write shadow; a busy layer defers it until busy drops.
  always_comb begin
    active_d = active_q;
    done_d   = commit_req && !layer_busy;
    pend_d   = commit_req && layer_busy;
    if (done_d) active_d = shadow_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      shadow_q <= '0;
      active_q <= '0;
      qptr_q   <= '0;
      err_q    <= 1'b0;
      pend_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      qptr_q   <= qptr_d;
      err_q    <= err_d;
      pend_q   <= pend_d;
      done_q   <= done_d;
    end
  end

  assign active_regs    = active_q;
  assign commit_pending = pend_q;
  assign commit_done    = done_q;
  assign cfg_err        = err_q;

  fs_accel_quant_buf #(
    .NUM_LANES  (NUM_LANES),
    .QBUF_DEPTH (QBUF_DEPTH),
    .GRP_W      (GRP_W)
  ) u_quant_buf (
    .clk         (clk),
    .resetn      (resetn),
    .mult_we     (mult_we),
    .shift_we    (shift_we),
    .addr        (qptr_q),
    .wdata       (cfg_wdata),
    .grp_sel     (quant_grp_sel),
    .rd_mult     (rd_mult),
    .rd_shift    (rd_shift),
    .quant_mult  (quant_mult),
    .quant_shift (quant_shift)
  );

`ifdef FS_ACCEL_CFG_READBACK_EN
  logic [31:0] rdata_d, rdata_q;
  logic        rvalid_q;

  always_comb begin
    rdata_d = rdata_q;
    if (cfg_ren) begin
      if (is_shadow) rdata_d = shadow_q[cfg_sel];
      else if (cfg_sel == SEL_QPTR)   rdata_d = {{(32-QPTR_W){1'b0}}, qptr_q};
      else if (cfg_sel == SEL_QMULT)  rdata_d = rd_mult;
      else if (cfg_sel == SEL_QSHIFT) rdata_d = {24'b0, rd_shift};
      else if (cfg_sel == SEL_STATUS) rdata_d = status;
      else                            rdata_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= cfg_ren;
    end
  end

  assign cfg_rdata  = rdata_q;
  assign cfg_rvalid = rvalid_q;
`else
  logic unused_rb;
  assign unused_rb  = ^{cfg_ren, rd_mult, rd_shift, status};
  assign cfg_rdata  = '0;
  assign cfg_rvalid = 1'b0;
`endif

endmodule

// File: tb/tb_fs_accel_cfg_regbank.sv
// Self-checking bench for fs_accel_cfg_regbank: directed scenarios plus random traffic
// against a behavioural model of the register map, commit and quant table rules.
module tb_fs_accel_cfg_regbank;

  localparam int NUM_REGS   = 19;
  localparam int NUM_LANES  = 3;
  localparam int QBUF_DEPTH = 36;
  localparam int GRP_W      = 4;
`ifdef FS_ACCEL_CFG_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    resetn, wen, ren, commit, busy;
  logic [4:0]              sel;
  logic [31:0]             wdata;
  logic [GRP_W-1:0]        grp;
  logic [31:0]             rdata;
  logic                    rvalid, pending, done, err;
  logic [NUM_REGS*32-1:0]  active;
  logic [NUM_LANES*32-1:0] qmult;
  logic [NUM_LANES*8-1:0]  qshift;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  logic [31:0]             m_shadow [NUM_REGS];
  logic [31:0]             m_active [NUM_REGS];
  logic [31:0]             m_mult   [QBUF_DEPTH];
  logic [7:0]              m_shift  [QBUF_DEPTH];
  int                      m_qptr;
  bit                      m_err, m_pend, m_done, m_rvalid;
  logic [31:0]             m_rdata;
  logic [NUM_LANES*32-1:0] m_qm;
  logic [NUM_LANES*8-1:0]  m_qs;

  fs_accel_cfg_regbank #(
    .NUM_REGS(NUM_REGS), .NUM_LANES(NUM_LANES), .QBUF_DEPTH(QBUF_DEPTH), .GRP_W(GRP_W)
  ) dut (
    .clk(clk), .resetn(resetn), .cfg_wen(wen), .cfg_sel(sel), .cfg_wdata(wdata),
    .cfg_ren(ren), .cfg_rdata(rdata), .cfg_rvalid(rvalid), .cfg_commit(commit),
    .layer_busy(busy), .commit_pending(pending), .commit_done(done),
    .quant_grp_sel(grp), .active_regs(active), .quant_mult(qmult),
    .quant_shift(qshift), .cfg_err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_read(input int s);
    if (s >= 12 && s <= 14) begin
      if (s == 12) return 32'(m_qptr);
      if (s == 13) return m_mult[m_qptr];
      return {24'b0, m_shift[m_qptr]};
    end
    if (s < NUM_REGS) return m_shadow[s];
    if (s == 30) return {29'b0, m_pend, busy, m_err};
    return 32'h0;
  endfunction

  function automatic logic [NUM_REGS*32-1:0] model_active();
    logic [NUM_REGS*32-1:0] v;
    for (int i = 0; i < NUM_REGS; i++) v[32*i +: 32] = m_active[i];
    return v;
  endfunction

  task automatic model_step();
    int  s;
    int  g;
    bit  req;
    s = int'(sel);
    g = int'(grp);
    if (!resetn) begin
      for (int i = 0; i < NUM_REGS; i++) begin m_shadow[i] = 0; m_active[i] = 0; end
      for (int i = 0; i < QBUF_DEPTH; i++) begin m_mult[i] = 0; m_shift[i] = 0; end
      m_qptr = 0; m_err = 0; m_pend = 0; m_done = 0; m_rvalid = 0; m_rdata = 0;
      m_qm = '0; m_qs = '0;
      return;
    end
    m_rvalid = ren;
    if (ren) m_rdata = model_read(s);
    m_qm = '0; m_qs = '0;
    if (g >= 1 && g <= QBUF_DEPTH / NUM_LANES)
      for (int k = 0; k < NUM_LANES; k++) begin
        m_qm[32*k +: 32] = m_mult[(g - 1) * NUM_LANES + k];
        m_qs[8*k +: 8]   = m_shift[(g - 1) * NUM_LANES + k];
      end
    req    = commit || m_pend;
    m_done = req && !busy;
    m_pend = req && busy;
    if (m_done)
      for (int i = 0; i < NUM_REGS; i++) m_active[i] = (i >= 12 && i <= 14) ? 32'h0 : m_shadow[i];
    if (wen) begin
      if (s >= 12 && s <= 14) begin
        if (busy) m_err = 1;
        else if (s == 12) begin
          if (wdata < QBUF_DEPTH) m_qptr = int'(wdata);
          else m_err = 1;
        end else if (s == 13) m_mult[m_qptr] = wdata;
        else begin
          m_shift[m_qptr] = wdata[7:0];
          m_qptr = (m_qptr + 1) % QBUF_DEPTH;
        end
      end else if (s < NUM_REGS) m_shadow[s] = wdata;
      else if (s == 31) m_err = 0;
      else m_err = 1;
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen = 0; ren = 0; commit = 0;
  endtask

  task automatic wr(input logic [4:0] s, input logic [31:0] d);
    wen = 1; sel = s; wdata = d;
    cyc();
    wen = 0;
  endtask

  task automatic test_reset();
    resetn = 0; idle(); busy = 0; sel = 0; wdata = 0; grp = 0;
    cyc(); cyc();
    n_tests++;
    if (active !== '0 || pending !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: active=%h pend=%b done=%b err=%b, want all 0", active, pending, done, err);
    end
    n_tests++;
    if (qmult !== '0 || qshift !== '0 || rdata !== 32'h0 || rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_data: qmult=%h qshift=%h rdata=%h rvalid=%b, want 0", qmult, qshift, rdata, rvalid);
    end
    resetn = 1;
    cyc();
  endtask

  task automatic test_commit_idle();
    wr(5'd6, 32'h0003_0003);
    commit = 1; cyc(); commit = 0;
    n_tests++;
    if (active[6*32 +: 32] !== 32'h0003_0003 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL commit_idle: word6=%h done=%b, want 00030003 1", active[6*32 +: 32], done);
    end
    cyc();
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL commit_done_pulse: done=%b, want 0", done);
    end
    // write and commit in the same cycle: active takes the old shadow
    wen = 1; sel = 5'd7; wdata = 32'hDEAD_0007; commit = 1;
    cyc(); idle();
    n_tests++;
    if (active[7*32 +: 32] !== 32'h0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL commit_prewrite: word7=%h done=%b, want 0 1", active[7*32 +: 32], done);
    end
    commit = 1; cyc(); commit = 0;
    n_tests++;
    if (active[7*32 +: 32] !== 32'hDEAD_0007) begin
      n_fail++;
      $display("FAIL commit_postwrite: word7=%h, want dead0007", active[7*32 +: 32]);
    end
  endtask

  task automatic test_commit_busy();
    busy = 1;
    wr(5'd8, 32'h0020_0020);
    commit = 1; cyc(); commit = 0;
    cyc(); cyc();
    n_tests++;
    if (pending !== 1'b1 || done !== 1'b0 || active[8*32 +: 32] !== 32'h0) begin
      n_fail++;
      $display("FAIL commit_busy_hold: pend=%b done=%b word8=%h, want 1 0 0", pending, done, active[8*32 +: 32]);
    end
    busy = 0; cyc();
    n_tests++;
    if (pending !== 1'b0 || done !== 1'b1 || active[8*32 +: 32] !== 32'h0020_0020) begin
      n_fail++;
      $display("FAIL commit_busy_release: pend=%b done=%b word8=%h, want 0 1 00200020", pending, done, active[8*32 +: 32]);
    end
  endtask

  task automatic test_quant_wrap();
    logic [31:0] exp_q [4];
    exp_q[0] = 34; exp_q[1] = 35; exp_q[2] = 0; exp_q[3] = 1;
    busy = 0;
    wr(5'd12, 32'd34);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        wr(5'd13, 32'hA + 32'(i - 1));
        wr(5'd14, 32'(i));
      end
      ren = 1; sel = 5'd12; cyc(); ren = 0;
      n_tests++;
      if (rdata !== (RB ? exp_q[i] : 32'h0) || rvalid !== RB) begin
        n_fail++;
        $display("FAIL qptr_step%0d: rdata=%h rvalid=%b, want %h %b", i, rdata, rvalid, RB ? exp_q[i] : 32'h0, RB);
      end
    end
    grp = 4'd1; cyc();
    n_tests++;
    if (qmult[31:0] !== 32'hC || qshift[7:0] !== 8'd3) begin
      n_fail++;
      $display("FAIL quant_grp1_lane0: mult=%h shift=%h, want c 03", qmult[31:0], qshift[7:0]);
    end
    grp = 4'd12; cyc();
    n_tests++;
    if (qmult !== {32'hB, 32'hA, 32'h0} || qshift !== {8'd2, 8'd1, 8'd0}) begin
      n_fail++;
      $display("FAIL quant_grp12: mult=%h shift=%h, want 0000000b0000000a00000000 020100", qmult, qshift);
    end
    grp = 4'd13; cyc();
    n_tests++;
    if (qmult !== '0 || qshift !== '0) begin
      n_fail++;
      $display("FAIL quant_grp_oor: mult=%h shift=%h, want 0", qmult, qshift);
    end
  endtask

  task automatic test_qptr_err();
    wr(5'd12, 32'd40);
    n_tests++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL qptr_oor_err: err=%b, want 1", err);
    end
    // qptr must still be 1: the next mult write lands on entry 1
    wr(5'd13, 32'h55);
    grp = 4'd1; cyc();
    n_tests++;
    if (qmult[63:32] !== 32'h55) begin
      n_fail++;
      $display("FAIL qptr_unchanged: lane1=%h, want 55", qmult[63:32]);
    end
    wr(5'd31, 32'h0);
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: err=%b, want 0", err);
    end
    busy = 1;
    wr(5'd13, 32'h77);
    busy = 0;
    cyc();
    n_tests++;
    if (err !== 1'b1 || qmult[63:32] !== 32'h55) begin
      n_fail++;
      $display("FAIL quant_busy_write: err=%b lane1=%h, want 1 55", err, qmult[63:32]);
    end
    wr(5'd31, 32'h0);
  endtask

  task automatic test_readback_status();
    busy = 1; commit = 1; cyc(); commit = 0;
    ren = 1; sel = 5'd30; cyc(); ren = 0;
    n_tests++;
    if (rdata !== (RB ? 32'h6 : 32'h0) || rvalid !== RB) begin
      n_fail++;
      $display("FAIL readback_status: rdata=%h rvalid=%b, want %h %b", rdata, rvalid, RB ? 32'h6 : 32'h0, RB);
    end
    cyc();
    n_tests++;
    if (rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL rvalid_pulse: rvalid=%b, want 0", rvalid);
    end
  endtask

  task automatic test_reset_pending();
    wr(5'd20, 32'h1);
    n_tests++;
    if (pending !== 1'b1 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_state: pend=%b err=%b, want 1 1", pending, err);
    end
    resetn = 0; cyc(); resetn = 1;
    n_tests++;
    if (pending !== 1'b0 || err !== 1'b0 || active !== '0 || qmult !== '0 || qshift !== '0 || rvalid !== 1'b0 || rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_pending: pend=%b err=%b active=%h qmult=%h", pending, err, active, qmult);
    end
    busy = 0; cyc();
    n_tests++;
    if (done !== 1'b0 || pending !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_discard: done=%b pend=%b, want 0 0", done, pending);
    end
  endtask

  task automatic test_random();
    logic [4:0] pick [8];
    pick[0] = 5'd12; pick[1] = 5'd13; pick[2] = 5'd14; pick[3] = 5'd30;
    pick[4] = 5'd31; pick[5] = 5'd2; pick[6] = 5'd18; pick[7] = 5'd25;
    for (int c = 0; c < 400; c++) begin
      resetn = ($urandom_range(0, 99) != 0);
      wen    = ($urandom_range(0, 1) == 1);
      ren    = ($urandom_range(0, 1) == 1);
      commit = ($urandom_range(0, 4) == 0);
      busy   = ($urandom_range(0, 3) == 0);
      sel    = ($urandom_range(0, 1) == 1) ? pick[$urandom_range(0, 7)] : 5'($urandom_range(0, 31));
      wdata  = (sel == 5'd12) ? 32'($urandom_range(0, 47)) : $urandom;
      grp    = GRP_W'($urandom_range(0, 15));
      cyc();
      n_tests++;
      if (active !== model_active() || pending !== m_pend || done !== m_done || err !== m_err) begin
        n_fail++;
        $display("FAIL rand_ctrl c%0d: pend=%b/%b done=%b/%b err=%b/%b active_ok=%b", c,
                 pending, m_pend, done, m_done, err, m_err, active === model_active());
      end
      n_tests++;
      if (qmult !== m_qm || qshift !== m_qs) begin
        n_fail++;
        $display("FAIL rand_quant c%0d: mult=%h want %h shift=%h want %h", c, qmult, m_qm, qshift, m_qs);
      end
      n_tests++;
      if (rdata !== (RB ? m_rdata : 32'h0) || rvalid !== (RB ? m_rvalid : 1'b0)) begin
        n_fail++;
        $display("FAIL rand_read c%0d: rdata=%h want %h rvalid=%b want %b", c, rdata,
                 RB ? m_rdata : 32'h0, rvalid, RB ? m_rvalid : 1'b0);
      end
    end
    idle(); resetn = 1; busy = 0;
  endtask

  initial begin
    test_reset();
    test_commit_idle();
    test_commit_busy();
    test_quant_wrap();
    test_qptr_err();
    test_readback_status();
    test_reset_pending();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
